// File: rtl/order_encoder.sv
// Order message serializer: queues buy/sell decisions and streams each as a byte message.
// Optional checksum byte is enabled by defining ORDER_CHECKSUM_EN.
module order_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buy,
  input  logic        sell,
  input  logic [31:0] price,
  input  logic [15:0] qty,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        drop,
  output logic [15:0] drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef ORDER_CHECKSUM_EN
  localparam int unsigned LEN = 10;
`else
  localparam int unsigned LEN = 9;
`endif
  localparam int unsigned MW       = LEN * 8;
  localparam logic [3:0]  LAST_IDX = 4'(LEN - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;

  logic [48:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic [7:0]    seq;
  logic [MW-1:0] msg, msg_load;
  logic [3:0]    idx;
  logic [48:0]   head;
  logic [71:0]   body;
  logic          pop, accept, push_ok, drop_d, single, full;

  assign single  = buy ^ sell;
  assign full    = (count == FULL_CNT);
  // A full FIFO still takes a push when the head is popped in the same cycle.
  assign push_ok = single && (!full || pop);
  assign drop_d  = (buy && sell) || (single && full && !pop);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          accept = 1'b1;
          if (idx == LAST_IDX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count;
    if (push_ok && !pop)      count_d = count + 1'b1;
    else if (!push_ok && pop) count_d = count - 1'b1;
  end

  assign head = mem[rd_ptr];
  assign body = {HDR, (head[48] ? 8'h42 : 8'h53), head[47:0], seq};

`ifdef ORDER_CHECKSUM_EN
  logic [7:0] cks;
  always_comb begin
    cks = '0;
    for (int unsigned i = 0; i < 9; i++) cks = cks ^ body[i*8 +: 8];
    msg_load = {body, cks};
  end
`else
  assign msg_load = body;
`endif

  assign tx_data  = msg[MW-1 -: 8];
  assign tx_valid = (state_q == SEND);
  assign tx_last  = tx_valid && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {buy, price, qty};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      msg      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      count <= count_d;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        msg    <= msg_load;
        idx    <= '0;
        seq    <= seq + 8'd1;
      end else if (accept) begin
        msg <= {msg[MW-9:0], 8'h00};
        idx <= idx + 4'd1;
      end
      busy <= (state_d == SEND) || (count_d != '0);
      drop <= drop_d;
      if (drop_d && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_order_encoder.sv
// Scoreboard bench for order_encoder: expected byte streams are queued at order issue
// and compared by an independent monitor on every handshake.
module tb_order_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1, buy = 1'b0, sell = 1'b0, tx_ready = 1'b0;
  logic [31:0] price = '0;
  logic [15:0] qty = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy, drop;
  logic [15:0] drop_cnt;

  order_encoder #(.DEPTH(DEPTH), .HDR(8'hA5)) dut (
    .clk(clk), .rst(rst), .buy(buy), .sell(sell), .price(price), .qty(qty),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .drop(drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          vecs = 0, errs = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  m_seq = '0;
  int          issued = 0, done = 0, aborted = 0;
  logic [15:0] exp_drops = '0;
  int          ready_mode = 0;
  int          pat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference message: header, side letter, price and qty big-endian, sequence number.
  task automatic expect_order(input logic is_buy, input logic [31:0] p, input logic [15:0] q);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(8'hA5);
    b.push_back(is_buy ? 8'h42 : 8'h53);
    for (int k = 3; k >= 0; k--) b.push_back(p[k*8 +: 8]);
    for (int k = 1; k >= 0; k--) b.push_back(q[k*8 +: 8]);
    b.push_back(m_seq);
`ifdef ORDER_CHECKSUM_EN
    x = '0;
    foreach (b[i]) x = x ^ b[i];
    b.push_back(x);
`else
    x = '0;
`endif
    foreach (b[i]) exp_q.push_back({(i == b.size() - 1), b[i]});
    m_seq = m_seq + 8'd1;
    issued++;
  endtask

  task automatic drive(input logic b, input logic s, input logic [31:0] p, input logic [15:0] q);
    @(posedge clk);
    #1;
    buy = b; sell = s; price = p; qty = q;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    vecs++;
    errs++;
    $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_q.size());
  endtask

  // Ready pattern: 0 = always, 1 = random, 2 = never, 3 = repeating 1,0,0.
  always @(posedge clk) begin
    #1;
    pat = (pat + 1) % 3;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ($urandom_range(0, 3) != 0);
      2: tx_ready = 1'b0;
      default: tx_ready = (pat == 0);
    endcase
  end

  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
        check("stall_last", 32'(tx_last), 32'(prev_last));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_byte: got %02h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e[7:0]));
          check("tx_last", 32'(tx_last), 32'(e[8]));
          if (e[8]) done++;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  initial begin
    logic [31:0] p;
    logic [15:0] q;
    int r, cnt, target;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single buy with latency checks
    drive(1'b1, 1'b0, 32'h0000_03E7, 16'h0010);
    expect_order(1'b1, 32'h0000_03E7, 16'h0010);
    @(negedge clk);
    check("lat_n_valid", 32'(tx_valid), 32'd0);
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("lat_n1_valid", 32'(tx_valid), 32'd0);
    check("lat_n1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_n2_valid", 32'(tx_valid), 32'd1);
    wait_drain(50);

    // Backpressure
    ready_mode = 3;
    drive(1'b1, 1'b0, 32'h0000_03E7, 16'h0010);
    expect_order(1'b1, 32'h0000_03E7, 16'h0010);
    drive(1'b0, 1'b0, '0, '0);
    wait_drain(100);
    ready_mode = 0;

    // Conflict
    drive(1'b1, 1'b1, $urandom, 16'($urandom));
    exp_drops = exp_drops + 16'd1;
    @(negedge clk);
    check("conf_drop_pre", 32'(drop), 32'd0);
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("conf_drop", 32'(drop), 32'd1);
    check("conf_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    check("conf_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("conf_drop_end", 32'(drop), 32'd0);
    check("conf_busy_end", 32'(busy), 32'd0);

    // Overflow with downstream stalled
    ready_mode = 2;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      p = $urandom;
      q = 16'($urandom);
      drive(1'b0, 1'b1, p, q);
      if (i < 5) expect_order(1'b0, p, q);
      else exp_drops = exp_drops + 16'd1;
      @(negedge clk);
      check("ovf_drop_quiet", 32'(drop), 32'd0);
    end
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("ovf_drop", 32'(drop), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    check("ovf_busy", 32'(busy), 32'd1);
    check("ovf_valid", 32'(tx_valid), 32'd1);
    check("ovf_hdr", 32'(tx_data), 32'hA5);
    ready_mode = 0;
    wait_drain(200);

    // Random traffic, long enough to wrap the sequence number
    ready_mode = 1;
    target = issued + 300;
    for (int c = 0; c < 20000 && issued < target; c++) begin
      r = $urandom_range(0, 15);
      p = $urandom;
      q = 16'($urandom);
      if (r == 0) begin
        drive(1'b1, 1'b1, p, q);
        exp_drops = exp_drops + 16'd1;
      end else if (r < 6 && (issued - done - aborted) < DEPTH) begin
        drive(r[0], !r[0], p, q);
        expect_order(r[0], p, q);
      end else begin
        drive(1'b0, 1'b0, '0, '0);
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    check("rand_issued", 32'(issued), 32'(target));
    wait_drain(5000);
    check("rand_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

    // Reset mid-message
    ready_mode = 0;
    repeat (2) @(posedge clk);
    drive(1'b1, 1'b0, 32'h1234_5678, 16'hBEEF);
    expect_order(1'b1, 32'h1234_5678, 16'hBEEF);
    drive(1'b0, 1'b0, '0, '0);
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 4; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) cnt++;
    end
    check("rst_mid_bytes_seen", 32'(cnt), 32'd4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    aborted++;
    m_seq = '0;
    exp_drops = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_drop_cnt", 32'(drop_cnt), 32'd0);
    drive(1'b1, 1'b0, 32'hCAFE_0001, 16'h0042);
    expect_order(1'b1, 32'hCAFE_0001, 16'h0042);
    drive(1'b0, 1'b0, '0, '0);
    wait_drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
